ipml_sync_prefetch_fifo_v2_0: RTL and testbench

Single-clock, parametrised first-word-fall-through FIFO. It combines an inferred simple-dual-port RAM with a registered read port, a 2-entry output prefetch buffer, programmable almost-full/almost-empty flags, an occupancy count and a synchronous flush. It is the next generation of the IP-core prefetch FIFOs, intended for same-clock datapaths such as sample buffers and DMA staging, where the dual-clock controller is unnecessary.

---
 rtl/ipml_sync_prefetch_fifo_v2_0.sv | 213 +++++++++++++++++++++
 tb/tb_ipml_sync_prefetch_fifo_v2_0.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipml_sync_prefetch_fifo_v2_0.sv
// ipml_sync_prefetch_fifo_v2_0
//   Single-clock first-word-fall-through FIFO. An inferred simple-dual-port
//   RAM with a registered read port feeds a 2-entry prefetch buffer whose
//   head drives rd_data. Total capacity is 2^c_DEPTH_WIDTH + 2 words.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   flush         synchronous clear of all contents (wins over wr_en/rd_en)
//   wr_data/wr_en write port; a write is accepted when wr_en & wr_vld
//   wr_vld        write ready (RAM not full)
//   rd_data       head-of-queue data, valid while rd_vld
//   rd_en         pop request; a pop occurs when rd_en & rd_vld
//   water_level   RAM words + in-flight read + buffered words
//   almost_full   water_level >= c_AFULL_LEVEL
//   almost_empty  water_level <= c_AEMPTY_LEVEL
//
// Optional build macro IPML_PREFETCH_FIFO_ERR_EN
//   Adds sticky error outputs wr_ovf (write while full) and rd_udf (read
//   while empty), cleared by reset or flush.

module ipml_sync_prefetch_fifo_v2_0 #(
    parameter int c_DATA_WIDTH   = 32,
    parameter int c_DEPTH_WIDTH  = 10,
    parameter int c_AFULL_LEVEL  = 2**c_DEPTH_WIDTH - 2,
    parameter int c_AEMPTY_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [c_DATA_WIDTH-1:0]    wr_data,
    input  logic                       wr_en,
    output logic                       wr_vld,
    output logic [c_DATA_WIDTH-1:0]    rd_data,
    input  logic                       rd_en,
    output logic                       rd_vld,
    output logic [c_DEPTH_WIDTH+1:0]   water_level,
    output logic                       almost_full,
    output logic                       almost_empty
`ifdef IPML_PREFETCH_FIFO_ERR_EN
    ,
    output logic                       wr_ovf,
    output logic                       rd_udf
`endif
);

    localparam int DEPTH = 2**c_DEPTH_WIDTH;
    localparam logic [c_DEPTH_WIDTH:0]   RAM_FULL   = (c_DEPTH_WIDTH+1)'(DEPTH);
    localparam logic [c_DEPTH_WIDTH+1:0] AFULL_LVL  = (c_DEPTH_WIDTH+2)'(c_AFULL_LEVEL);
    localparam logic [c_DEPTH_WIDTH+1:0] AEMPTY_LVL = (c_DEPTH_WIDTH+2)'(c_AEMPTY_LEVEL);

    // ------------------------------------------------------------------
    // Reset: asynchronous assertion, release synchronised by two flops
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end

    assign rst_int_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_DEPTH_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic                     inflight_q, inflight_d;
    logic [1:0]               buf_cnt_q, buf_cnt_d;
    logic [c_DATA_WIDTH-1:0]  buf0_q, buf0_d;
    logic [c_DATA_WIDTH-1:0]  buf1_q, buf1_d;
    logic [c_DATA_WIDTH-1:0]  ram_rdata_q;
    logic [c_DATA_WIDTH-1:0]  mem [0:DEPTH-1];

    logic       push;
    logic       pop;
    logic       rd_issue;
    logic [2:0] occ_after_pop;
    logic [1:0] remain;

    // ------------------------------------------------------------------
    // Handshakes and prefetch decision
    // ------------------------------------------------------------------
    assign wr_vld = (ram_cnt_q != RAM_FULL);
    assign rd_vld = (buf_cnt_q != 2'd0);
    assign rd_data = buf0_q;

    assign push = wr_en & wr_vld & ~flush;
    assign pop  = rd_en & rd_vld & ~flush;

    // Issue a RAM read whenever the buffer plus the in-flight word, after
    // this cycle's pop, leaves room for the returned word.
    assign occ_after_pop = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(pop);
    assign rd_issue      = ~flush & (ram_cnt_q != '0) & (occ_after_pop < 3'd2);

    // ------------------------------------------------------------------
    // RAM with registered read port (contents survive flush and reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push)     mem[wr_ptr_q] <= wr_data;
        if (rd_issue) ram_rdata_q   <= mem[rd_ptr_q];
    end

    // ------------------------------------------------------------------
    // Pointer / counter next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ram_cnt_d  = ram_cnt_q;
        inflight_d = 1'b0;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            ram_cnt_d = '0;
        end else begin
            if (push)     wr_ptr_d = wr_ptr_q + c_DEPTH_WIDTH'(1);
            if (rd_issue) rd_ptr_d = rd_ptr_q + c_DEPTH_WIDTH'(1);
            ram_cnt_d  = ram_cnt_q + (c_DEPTH_WIDTH+1)'(push)
                                   - (c_DEPTH_WIDTH+1)'(rd_issue);
            inflight_d = rd_issue;
        end
    end

    // ------------------------------------------------------------------
    // Prefetch buffer: shift on pop, then append the returning RAM word
    // behind whatever remains.
    // ------------------------------------------------------------------
    always_comb begin
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        buf_cnt_d = buf_cnt_q;
        remain    = buf_cnt_q;
        if (flush) begin
            buf_cnt_d = '0;
        end else begin
            if (pop) begin
                buf0_d = buf1_q;
                remain = buf_cnt_q - 2'd1;
            end
            buf_cnt_d = remain;
            if (inflight_q) begin
                if (remain == 2'd0) buf0_d = ram_rdata_q;
                else                buf1_d = ram_rdata_q;
                buf_cnt_d = remain + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= '0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

    // ------------------------------------------------------------------
    // Occupancy and threshold flags
    // ------------------------------------------------------------------
    assign water_level  = (c_DEPTH_WIDTH+2)'(ram_cnt_q)
                        + (c_DEPTH_WIDTH+2)'(inflight_q)
                        + (c_DEPTH_WIDTH+2)'(buf_cnt_q);
    assign almost_full  = (water_level >= AFULL_LVL);
    assign almost_empty = (water_level <= AEMPTY_LVL);

`ifdef IPML_PREFETCH_FIFO_ERR_EN
    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic wr_ovf_q, wr_ovf_d;
    logic rd_udf_q, rd_udf_d;

    always_comb begin
        wr_ovf_d = 1'b0;
        rd_udf_d = 1'b0;
        if (!flush) begin
            wr_ovf_d = wr_ovf_q | (wr_en & ~wr_vld);
            rd_udf_d = rd_udf_q | (rd_en & ~rd_vld);
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_ovf_q <= 1'b0;
            rd_udf_q <= 1'b0;
        end else begin
            wr_ovf_q <= wr_ovf_d;
            rd_udf_q <= rd_udf_d;
        end
    end

    assign wr_ovf = wr_ovf_q;
    assign rd_udf = rd_udf_q;
`endif

endmodule

// File: tb/tb_ipml_sync_prefetch_fifo_v2_0.sv
// Self-checking bench for ipml_sync_prefetch_fifo_v2_0 (depth 16, 8-bit data).
// A queue holds the expected contents; water_level, flags and head data are
// compared against it. IPML_PREFETCH_FIFO_ERR_EN enables the error-flag test.
`timescale 1ns/1ps

module tb_ipml_sync_prefetch_fifo_v2_0;

    localparam int W   = 8;
    localparam int DW  = 4;
    localparam int AF  = 14;
    localparam int AE  = 1;
    localparam int CAP = 18;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          wr_en = 1'b0;
    logic          wr_vld;
    logic [W-1:0]  rd_data;
    logic          rd_en = 1'b0;
    logic          rd_vld;
    logic [DW+1:0] water_level;
    logic          almost_full;
    logic          almost_empty;
`ifdef IPML_PREFETCH_FIFO_ERR_EN
    logic          wr_ovf;
    logic          rd_udf;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] q[$];

    always #5 clk = ~clk;

    ipml_sync_prefetch_fifo_v2_0 #(
        .c_DATA_WIDTH   (W),
        .c_DEPTH_WIDTH  (DW),
        .c_AFULL_LEVEL  (AF),
        .c_AEMPTY_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .wr_vld       (wr_vld),
        .rd_data      (rd_data),
        .rd_en        (rd_en),
        .rd_vld       (rd_vld),
        .water_level  (water_level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef IPML_PREFETCH_FIFO_ERR_EN
        ,
        .wr_ovf       (wr_ovf),
        .rd_udf       (rd_udf)
`endif
    );

    // Drive one clock cycle from a negedge, update the reference queue at the
    // posedge, return at the following negedge.
    task automatic cycle(input logic we, input logic [W-1:0] wd,
                         input logic re, input logic fl);
        logic pushed, popped;
        wr_en = we; wr_data = wd; rd_en = re; flush = fl;
        pushed = we && wr_vld && !fl;
        popped = re && rd_vld && !fl;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (popped && q.size() > 0) void'(q.pop_front());
            if (pushed) q.push_back(wd);
        end
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL reset_rd_vld: got %b expected 0", rd_vld); end
        n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
        n_checks++; if (wr_vld !== 1'b1) begin n_fail++; $display("FAIL reset_wr_vld: got %b expected 1", wr_vld); end
        n_checks++; if (water_level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", water_level); end
        n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b expected 0", almost_full); end
        n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b expected 1", almost_empty); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        q.delete();
    endtask

    task automatic test_first_word();
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        n_checks++; if (water_level !== 6'd1) begin n_fail++; $display("FAIL fw_level_e0: got %0d expected 1", water_level); end
        n_checks++; if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL fw_vld_e0: got %b expected 0", rd_vld); end
        cycle(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL fw_vld_e1: got %b expected 0", rd_vld); end
        n_checks++; if (water_level !== 6'd1) begin n_fail++; $display("FAIL fw_level_e1: got %0d expected 1", water_level); end
        cycle(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (rd_vld !== 1'b1) begin n_fail++; $display("FAIL fw_vld_e2: got %b expected 1", rd_vld); end
        n_checks++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL fw_data_e2: got %0h expected a5", rd_data); end
        n_checks++; if (water_level !== 6'd1) begin n_fail++; $display("FAIL fw_level_e2: got %0d expected 1", water_level); end
        n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL fw_aempty: got %b expected 1", almost_empty); end
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_checks++; if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL fw_vld_pop: got %b expected 0", rd_vld); end
        n_checks++; if (water_level !== 6'd0) begin n_fail++; $display("FAIL fw_level_pop: got %0d expected 0", water_level); end
    endtask

    task automatic test_fill();
        int acc;
        acc = 0;
        for (int c = 0; c < 24; c++) begin
            n_checks++; if (wr_vld !== (acc < CAP)) begin n_fail++; $display("FAIL fill_wr_vld: got %b expected %b at %0d words", wr_vld, acc < CAP, acc); end
            if (wr_vld) acc++;
            cycle(1'b1, W'(acc - (wr_vld ? 1 : 0)), 1'b0, 1'b0);
        end
        n_checks++; if (acc !== CAP) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", acc, CAP); end
        n_checks++; if (water_level !== 6'(CAP)) begin n_fail++; $display("FAIL fill_level: got %0d expected %0d", water_level, CAP); end
        n_checks++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL fill_afull: got %b expected 1", almost_full); end
        n_checks++; if (almost_empty !== 1'b0) begin n_fail++; $display("FAIL fill_aempty: got %b expected 0", almost_empty); end
        for (int i = 0; i < CAP; i++) begin
            n_checks++; if (rd_vld !== 1'b1) begin n_fail++; $display("FAIL drain_vld: got %b expected 1 at word %0d", rd_vld, i); end
            n_checks++; if (rd_data !== W'(i)) begin n_fail++; $display("FAIL drain_data: got %0h expected %0h", rd_data, W'(i)); end
            n_checks++; if (water_level !== 6'(CAP - i)) begin n_fail++; $display("FAIL drain_level: got %0d expected %0d", water_level, CAP - i); end
            n_checks++; if (almost_full !== (CAP - i >= AF)) begin n_fail++; $display("FAIL drain_afull: got %b expected %b", almost_full, CAP - i >= AF); end
            if (i == 2) begin
                n_checks++; if (wr_vld !== 1'b1) begin n_fail++; $display("FAIL drain_wr_vld: got %b expected 1", wr_vld); end
            end
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        n_checks++; if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL drain_empty_vld: got %b expected 0", rd_vld); end
        n_checks++; if (water_level !== 6'd0) begin n_fail++; $display("FAIL drain_empty_level: got %0d expected 0", water_level); end
    endtask

    task automatic test_back_to_back();
        int exp_out;
        bit started;
        exp_out = 0; started = 0;
        for (int c = 0; c < 70; c++) begin
            if (started) begin
                n_checks++; if (rd_vld !== 1'b1) begin n_fail++; $display("FAIL b2b_bubble: got %b expected 1 at cycle %0d", rd_vld, c); end
                n_checks++; if (water_level !== 6'd3) begin n_fail++; $display("FAIL b2b_level: got %0d expected 3", water_level); end
            end
            if (rd_vld) begin
                if (!started) begin
                    n_checks++; if (c !== 3) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 3", c); end
                end
                started = 1;
                n_checks++; if (rd_data !== W'(exp_out)) begin n_fail++; $display("FAIL b2b_data: got %0h expected %0h", rd_data, W'(exp_out)); end
                exp_out++;
            end
            cycle(1'b1, W'(c), 1'b1, 1'b0);
        end
        n_checks++; if (exp_out !== 67) begin n_fail++; $display("FAIL b2b_count: got %0d expected 67", exp_out); end
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_hold();
        logic [W-1:0] x;
        x = W'($urandom);
        cycle(1'b1, x, 1'b0, 1'b0);
        for (int i = 0; i < 5 && !rd_vld; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (rd_vld !== 1'b1) begin n_fail++; $display("FAIL hold_wait: got %b expected 1", rd_vld); end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, W'($urandom), 1'b0, 1'b0);
            n_checks++; if (rd_data !== x || rd_vld !== 1'b1) begin n_fail++; $display("FAIL hold_data: got %0h/%b expected %0h/1", rd_data, rd_vld, x); end
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_checks++; if (rd_data !== q[0]) begin n_fail++; $display("FAIL hold_next: got %0h expected %0h", rd_data, q[0]); end
        n_checks++; if (water_level !== 6'd6) begin n_fail++; $display("FAIL hold_level: got %0d expected 6", water_level); end
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        logic [W-1:0] y;
        for (int i = 0; i < 7; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (water_level !== 6'd7) begin n_fail++; $display("FAIL flush_pre_level: got %0d expected 7", water_level); end
        cycle(1'b1, 8'h3C, 1'b1, 1'b1);
        n_checks++; if (water_level !== 6'd0) begin n_fail++; $display("FAIL flush_level: got %0d expected 0", water_level); end
        n_checks++; if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL flush_vld: got %b expected 0", rd_vld); end
        n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL flush_aempty: got %b expected 1", almost_empty); end
        repeat (4) cycle(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (rd_vld !== 1'b0 || water_level !== 6'd0) begin n_fail++; $display("FAIL flush_dropped: got vld %b level %0d expected 0 0", rd_vld, water_level); end
        y = W'($urandom);
        cycle(1'b1, y, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (rd_vld !== 1'b1 || rd_data !== y) begin n_fail++; $display("FAIL flush_after: got %0h/%b expected %0h/1", rd_data, rd_vld, y); end
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int sz;
        logic we, re, fl;
        for (int c = 0; c < 600; c++) begin
            sz = q.size();
            n_checks++; if (water_level !== 6'(sz)) begin n_fail++; $display("FAIL rnd_level: got %0d expected %0d at cycle %0d", water_level, sz, c); end
            n_checks++; if (almost_full !== (sz >= AF)) begin n_fail++; $display("FAIL rnd_afull: got %b expected %b", almost_full, sz >= AF); end
            n_checks++; if (almost_empty !== (sz <= AE)) begin n_fail++; $display("FAIL rnd_aempty: got %b expected %b", almost_empty, sz <= AE); end
            if (sz == 0) begin
                n_checks++; if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL rnd_vld_empty: got %b expected 0", rd_vld); end
            end else if (rd_vld) begin
                n_checks++; if (rd_data !== q[0]) begin n_fail++; $display("FAIL rnd_data: got %0h expected %0h", rd_data, q[0]); end
            end
            if (sz < 16) begin
                n_checks++; if (wr_vld !== 1'b1) begin n_fail++; $display("FAIL rnd_wr_vld: got %b expected 1 at level %0d", wr_vld, sz); end
            end else if (sz == CAP) begin
                n_checks++; if (wr_vld !== 1'b0) begin n_fail++; $display("FAIL rnd_full: got %b expected 0", wr_vld); end
            end
            if ((c / 150) % 2 == 0) begin
                we = ($urandom_range(0, 3) != 0); re = ($urandom_range(0, 3) == 0);
            end else begin
                we = ($urandom_range(0, 3) == 0); re = ($urandom_range(0, 3) != 0);
            end
            fl = ($urandom_range(0, 79) == 0);
            cycle(we, W'($urandom), re, fl);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (water_level !== 6'd0) begin n_fail++; $display("FAIL arst_level: got %0d expected 0", water_level); end
        n_checks++; if (rd_vld !== 1'b0 || rd_data !== '0) begin n_fail++; $display("FAIL arst_rd: got %0h/%b expected 0/0", rd_data, rd_vld); end
        n_checks++; if (wr_vld !== 1'b1) begin n_fail++; $display("FAIL arst_wr_vld: got %b expected 1", wr_vld); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        q.delete();
        n_checks++; if (rd_vld !== 1'b0 || water_level !== 6'd0) begin n_fail++; $display("FAIL arst_release: got vld %b level %0d expected 0 0", rd_vld, water_level); end
    endtask

`ifdef IPML_PREFETCH_FIFO_ERR_EN
    task automatic test_err_flags();
        n_checks++; if (wr_ovf !== 1'b0 || rd_udf !== 1'b0) begin n_fail++; $display("FAIL err_init: got %b%b expected 00", wr_ovf, rd_udf); end
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_checks++; if (rd_udf !== 1'b1) begin n_fail++; $display("FAIL err_udf: got %b expected 1", rd_udf); end
        n_checks++; if (wr_ovf !== 1'b0) begin n_fail++; $display("FAIL err_no_ovf: got %b expected 0", wr_ovf); end
        for (int i = 0; i < CAP; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
        n_checks++; if (wr_ovf !== 1'b0) begin n_fail++; $display("FAIL err_ovf_early: got %b expected 0", wr_ovf); end
        cycle(1'b1, W'($urandom), 1'b0, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (wr_ovf !== 1'b1 || rd_udf !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b%b expected 11", wr_ovf, rd_udf); end
        cycle(1'b0, '0, 1'b0, 1'b1);
        n_checks++; if (wr_ovf !== 1'b0 || rd_udf !== 1'b0) begin n_fail++; $display("FAIL err_flush: got %b%b expected 00", wr_ovf, rd_udf); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_first_word();
        test_fill();
        test_back_to_back();
        test_hold();
        test_flush();
        test_random();
        test_async_reset();
`ifdef IPML_PREFETCH_FIFO_ERR_EN
        test_err_flags();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
